rom_burst: RTL and testbench
============================

ROM_BURST -- requirements
Module: rom_burst

Interface
REQ-001 The block SHALL take parameter AW, default 8, address width in bits (ROM depth 2**AW words).
REQ-002 The block SHALL take parameter DW, default 8, data word width in bits.
REQ-003 The block SHALL take parameter LW, default 4, burst-length field width (max burst 2**LW words).
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  burst request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_addr  input  AW  start address of burst.
REQ-010 req_len  input  LW  burst length minus one (0 = single word).
REQ-011 rsp_valid  output  1  rsp_data holds a valid word.
REQ-012 rsp_ready  input  1  consumer accepts the word.
REQ-013 rsp_data  output  DW  ROM word.
REQ-014 rsp_last  output  1  current word is the final word of the burst.
REQ-015 busy  output  1  burst in progress (state BURST).

Function
REQ-016 ROM content SHALL be: word(a) = a zero-extended/truncated to DW, with bit 3 cleared when a[4:0] = 5'b11000 (e.g. 24->16, 56->48, 248->240); all other addresses return a.
REQ-017 FSM SHALL have states IDLE and BURST; req_ready SHALL be 1 exactly in IDLE.
REQ-018 Request handshake: req_valid & req_ready at edge t latches addr and remaining count = req_len, moves to BURST; req_addr/req_len ignored otherwise.
REQ-019 First word SHALL appear with rsp_valid = 1 in the cycle after acceptance (latency 1, registered output).
REQ-020 Response handshake: a word transfers when rsp_valid & rsp_ready; next word (addr+1) SHALL be presented the following cycle, giving one word per cycle under continuous rsp_ready.
REQ-021 While rsp_valid & !rsp_ready, rsp_data, rsp_last and rsp_valid SHALL hold stable; address and count SHALL not advance.
REQ-022 Address increment SHALL wrap modulo 2**AW (255 -> 0 at AW=8) with no error indication.
REQ-023 rsp_last SHALL be 1 exactly on the word where remaining count = 0.
REQ-024 Transfer of the last word SHALL return FSM to IDLE: rsp_valid = 0 and req_ready = 1 in the next cycle; no back-to-back overlap with a new burst.
REQ-025 busy SHALL equal (state == BURST); rsp_valid SHALL never be 1 in IDLE.
REQ-026 Total words delivered per burst SHALL be req_len+1, all words exactly as REQ-016.

Reset
REQ-027 On rst_n low, asynchronously: state = IDLE, rsp_valid = 0, rsp_last = 0, rsp_data = 0, address and count = 0, busy = 0, req_ready = 1 after release.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; no residual word SHALL be emitted after release.

Structure
REQ-029 A shared package rom_pkg SHALL hold the state enumeration and the content function of REQ-016 (parametrised by AW/DW).
REQ-030 A sub-module rom_content (combinational address -> word lookup) SHALL be instantiated once; all sequencing stays in rom_burst.

Verification
REQ-031 Reset then single request addr=5, len=0 -> one word 5 with rsp_last=1 one cycle after acceptance, then req_ready=1.
REQ-032 Burst addr=20, len=7, rsp_ready=1 -> words 20,21,22,23,16,25,26,27 on consecutive cycles, rsp_last only on 27.
REQ-033 Burst addr=254, len=3 -> words 254,255,0,1 (wrap), rsp_last on 1.
REQ-034 Burst addr=56, len=2 with rsp_ready low 3 cycles on first word -> 48 held stable 3 cycles, then 57, 58; no word lost or duplicated.
REQ-035 rst_n pulsed low during 3rd word of burst addr=0, len=15 -> rsp_valid=0 immediately, IDLE/req_ready=1 after release, no further words.
REQ-036 req_valid held high while busy with different addr -> ignored until IDLE; full address sweep 0..255 (16 bursts len=15) matches REQ-016 model.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and ROM content rule for the burst-read ROM.
package rom_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   // Word stored at address a: the address itself, trimmed to dw bits, with
   // bit 3 cleared whenever the low five address bits are 5'b11000.
   // Addresses and words wider than 32 bits are not supported.
   function automatic logic [31:0] rom_word(input logic [31:0] a, input int aw, input int dw);
      logic [31:0] w;
      w = (aw >= 32) ? a : (a & ((32'd1 << aw) - 32'd1));
      if (w[4:0] == 5'b11000) begin
         w[3] = 1'b0;
      end
      if (dw < 32) begin
         w = w & ((32'd1 << dw) - 32'd1);
      end
      return w;
   endfunction

endpackage

// File: rtl/rom_content.sv
// Combinational address-to-word lookup for the burst-read ROM.
module rom_content
   import rom_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] word
);

   // Pure function of the address; no storage, so nothing to reset.
   assign word = DW'(rom_word(32'(addr), AW, DW));

endmodule

// File: rtl/rom_burst.sv
// Burst reader: accepts (addr, len) requests and streams len+1 consecutive
// ROM words over a valid/ready response channel, one word per cycle.
module rom_burst
   import rom_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [LW-1:0] req_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          busy
);

   state_t        state;
   logic [AW-1:0] addr;          // address of the word currently presented
   logic [LW-1:0] cnt;           // words remaining after the presented one
   logic [AW-1:0] lookup_addr;
   logic [DW-1:0] lookup_word;

   // Address of the word to load next: request start in IDLE, successor in BURST
   // (AW-bit add, so it wraps naturally at the top of the ROM).
   always_comb begin
      lookup_addr = (state == S_IDLE) ? req_addr : addr + AW'(1);
   end

   rom_content #(
      .AW (AW),
      .DW (DW)
   ) u_rom_content (
      .addr (lookup_addr),
      .word (lookup_word)
   );

   assign req_ready = (state == S_IDLE);
   assign busy      = (state == S_BURST);

   // Burst sequencer with registered response outputs.
   // NOTE: non-blocking assignments so every flop here samples pre-edge values;
   // blocking ones would make the result depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  state     <= S_BURST;
                  addr      <= req_addr;
                  cnt       <= req_len;
                  rsp_valid <= 1'b1;
                  rsp_data  <= lookup_word;
                  rsp_last  <= (req_len == '0);
               end
            end
            S_BURST: begin
               // Outputs, address and count all hold while the consumer stalls.
               if (rsp_ready) begin
                  if (cnt == '0) begin
                     state     <= S_IDLE;
                     rsp_valid <= 1'b0;
                     rsp_last  <= 1'b0;
                  end else begin
                     addr     <= lookup_addr;
                     cnt      <= cnt - LW'(1);
                     rsp_data <= lookup_word;
                     rsp_last <= (cnt == LW'(1));
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               rsp_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_burst.sv
// Self-checking bench for rom_burst: directed bursts plus randomized bursts,
// stalls and request noise, checked against a queue-based reference model.
module tb_rom_burst;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LW = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [LW-1:0] req_len   = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   rom_burst #(
      .AW (AW),
      .DW (DW),
      .LW (LW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference ROM content, from the address arithmetic alone.
   function automatic int model_word(input int a);
      int w;
      w = a % (1 << AW);
      if (w % 32 == 24) w = w - 8;
      return w % (1 << DW);
   endfunction

   // Issue one burst and follow it to completion.
   // mode 0: consumer always ready; 1: random ready; 2: first word stalled 3 cycles.
   // noise: keep req_valid high with random addr/len while the burst runs.
   task automatic run_burst(input int a, input int len, input int mode, input bit noise);
      int qd[$];
      bit ql[$];
      int cyc;
      int held;
      bit done;
      for (int i = 0; i <= len; i++) begin
         qd.push_back(model_word(a + i));
         ql.push_back(i == len);
      end
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a[AW-1:0];
      req_len   = len[LW-1:0];
      rsp_ready = 1'b1;
      cyc  = 0;
      held = 0;
      done = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (noise) begin
            req_valid = 1'b1;
            req_addr  = AW'($urandom);
            req_len   = LW'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         check("rsp_valid", 32'(rsp_valid), 32'(qd.size() != 0));
         check("busy",      32'(busy),      32'(qd.size() != 0));
         check("req_ready", 32'(req_ready), 32'(qd.size() == 0));
         if (qd.size() == 0) begin
            done      = 1'b1;
            req_valid = 1'b0;
         end else begin
            check("rsp_data", 32'(rsp_data), qd[0]);
            check("rsp_last", 32'(rsp_last), 32'(ql[0]));
            case (mode)
               0:       rsp_ready = 1'b1;
               1:       rsp_ready = 1'($urandom % 2);
               default: rsp_ready = !(qd.size() == len + 1 && held < 3);
            endcase
            if (!rsp_ready) held++;
            if (rsp_ready) begin
               void'(qd.pop_front());
               void'(ql.pop_front());
               if (qd.size() == 0) req_valid = 1'b0;
            end
         end
      end
      check("burst_done", 32'(done), 32'd1);
      if (mode == 0) check("burst_cycles", cyc, len + 2);
      if (mode == 2) check("stall_burst_cycles", cyc, len + 5);
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_last",  32'(rsp_last),  32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Single word, burst with the bit-3 rule, wrap, stalled first word
      run_burst(5,   0, 0, 1'b0);
      run_burst(20,  7, 0, 1'b0);
      run_burst(254, 3, 0, 1'b0);
      run_burst(56,  2, 2, 1'b0);

      // Reset during the third word of a 16-word burst
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = '0;
      req_len   = LW'(15);
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_w0", 32'(rsp_data), 32'(model_word(0)));
      @(negedge clk);
      check("mid_w1", 32'(rsp_data), 32'(model_word(1)));
      @(negedge clk);
      check("mid_w2_valid", 32'(rsp_valid), 32'd1);
      check("mid_w2", 32'(rsp_data), 32'(model_word(2)));
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy",      32'(busy),      32'd0);
      check("mid_rst_rsp_data",  32'(rsp_data),  32'd0);
      check("mid_rst_rsp_last",  32'(rsp_last),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("after_rst_req_ready", 32'(req_ready), 32'd1);
      end

      // Full address sweep with random stalls and request noise while busy
      for (int k = 0; k < 16; k++) begin
         run_burst(16 * k, 15, 1, 1'b1);
      end

      // Random bursts
      for (int k = 0; k < 12; k++) begin
         run_burst(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(2, 0)), 1'($urandom % 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
